// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage with one outstanding imem request, a one-entry skid and redirect drop.
// Define IF_PERF_CNT_EN to add the fetch_count / bubble_count outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstructionIF,
    output logic [31:0] PC4IF,
    output logic        fetch_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    // state | meaning
    // RUN   | normal fetching, responses are accepted
    // DROP  | a pre-redirect request is outstanding, its response is discarded
    typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic        fv_q, fv_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        issue;
    logic        accept;
    logic        buf_free;
    logic [31:0] pc_plus4;

    // A new request may issue while the buffer is held, as long as the skid can absorb it.
    assign issue     = (state_q == RUN) && !pend_q && !skid_v_q && !redirect;
    assign imem_req  = reset && (pend_q || issue);
    assign imem_addr = pend_q ? addr_q : pc_q;
    assign accept    = imem_req && imem_ready && (state_q == RUN) && !redirect;
    assign buf_free  = !fv_q || !hold;
    assign pc_plus4  = pc_q + 32'd4;

    assign fetch_valid   = fv_q;
    assign InstructionIF = instr_q;
    assign PC4IF         = pc4_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = imem_addr;
        pend_d       = imem_req && !imem_ready;
        fv_d         = fv_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect) begin
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            fv_d         = 1'b0;
            instr_d      = 32'h0;
            pc4_d        = 32'h0;
            skid_v_d     = 1'b0;
            skid_instr_d = 32'h0;
            skid_pc4_d   = 32'h0;
            state_d      = (imem_req && !imem_ready) ? DROP : RUN;
        end else begin
            if (state_q == DROP && imem_ready) begin
                state_d = RUN;
            end
            if (accept) begin
                pc_d = pc_plus4;
            end
            if (buf_free) begin
                if (skid_v_q) begin
                    fv_d     = 1'b1;
                    instr_d  = skid_instr_q;
                    pc4_d    = skid_pc4_q;
                    skid_v_d = 1'b0;
                end else if (accept) begin
                    fv_d    = 1'b1;
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                end else begin
                    fv_d    = 1'b0;
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                end
            end else if (accept) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc4_d   = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            pend_q       <= 1'b0;
            fv_q         <= 1'b0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            pend_q       <= pend_d;
            fv_q         <= fv_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!hold && !fv_q) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory model feeding a scoreboard, plus directed checks.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] InstructionIF;
    logic [31:0] PC4IF;
    logic        fetch_valid;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          wcnt = 0;
    bit          discard_next = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_addr = 32'h0000_0040;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .InstructionIF(InstructionIF),
        .PC4IF        (PC4IF),
        .fetch_valid  (fetch_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2400_0003;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: ready once a request has been visible for lat full cycles.
    always @(posedge clk) begin
        #3;
        imem_ready = imem_req && (wcnt >= lat);
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'h0;
    end

    // Each completed, non-discarded handshake is the stimulus that produces one expected instruction.
    always @(negedge clk) begin
        if (imem_req && imem_ready) begin
            if (!redirect) begin
                if (discard_next) begin
                    discard_next = 1'b0;
                end else begin
                    check32("fetch_addr", imem_addr, exp_addr);
                    sb_q.push_back({exp_addr + 32'd4, mem_word(exp_addr)});
                    exp_addr = exp_addr + 32'd4;
                end
            end
            wcnt = 0;
        end else if (imem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: IF/ID captures the buffer at every edge with hold low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fetch_valid && !hold) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc4 %h instr %h, expected no instruction", PC4IF, InstructionIF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check32("sb_pc4", PC4IF, mon_e[63:32]);
                    check32("sb_instr", InstructionIF, mon_e[31:0]);
                end
            end else if (!fetch_valid) begin
                check32("bubble_instr", InstructionIF, 32'h0);
                check32("bubble_pc4", PC4IF, 32'h0);
            end
        end
    end

    initial begin
        int n;

        // Reset, then zero-wait streaming from RESET_PC
        repeat (3) tick();
        mon_en = 1'b1;
        check32("rst_req", {31'h0, imem_req}, 32'h0);
        check32("rst_valid", {31'h0, fetch_valid}, 32'h0);
        check32("rst_instr", InstructionIF, 32'h0);
        check32("rst_pc4", PC4IF, 32'h0);
        reset = 1'b1;
        #1;
        check32("first_req", {31'h0, imem_req}, 32'h1);
        check32("first_addr", imem_addr, 32'h0000_0040);
        tick();
        check32("stream_pc4_0", PC4IF, 32'h0000_0044);
        tick();
        check32("stream_pc4_1", PC4IF, 32'h0000_0048);
        tick();
        check32("stream_pc4_2", PC4IF, 32'h0000_004C);

        // 3-cycle memory: one valid every third cycle
        lat = 2;
        repeat (3) tick();
        n = 0;
        for (int i = 0; i < 9; i++) begin
            if (fetch_valid) n++;
            tick();
        end
        check32("slow_pulses", n, 32'd3);

        // Hold 4 cycles with a response arriving into the skid
        lat = 0;
        repeat (3) tick();
        check32("pre_hold_valid", {31'h0, fetch_valid}, 32'h1);
        check32("pre_hold_pc4", PC4IF, 32'h0000_0068);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check32("hold_pc4", PC4IF, 32'h0000_0068);
            check32("hold_instr", InstructionIF, mem_word(32'h0000_0064));
            if (i > 0) check32("hold_no_req", {31'h0, imem_req}, 32'h0);
            tick();
        end
        hold = 1'b0;
        tick();
        check32("skid_deliver", PC4IF, 32'h0000_006C);
        tick();
        check32("after_skid", PC4IF, 32'h0000_0070);

        // Redirect to 0x20, then redirect to 0x1003 while 0x20 is outstanding
        redirect = 1'b1;
        redirect_pc = 32'h0000_0020;
        exp_addr = 32'h0000_0020;
        #1;
        check32("redir_no_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        lat = 2;
        #1;
        check32("redir_addr_20", imem_addr, 32'h0000_0020);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_1003;
        discard_next = 1'b1;
        exp_addr = 32'h0000_1000;
        tick();
        redirect = 1'b0;
        #1;
        check32("drop_req", {31'h0, imem_req}, 32'h1);
        check32("drop_addr", imem_addr, 32'h0000_0020);
        tick();
        check32("target_addr", imem_addr, 32'h0000_1000);
        check32("target_bubble", {31'h0, fetch_valid}, 32'h0);
        n = 0;
        while (!fetch_valid && n < 10) begin
            tick();
            n++;
        end
        check32("target_valid", {31'h0, fetch_valid}, 32'h1);
        check32("target_pc4", PC4IF, 32'h0000_1004);
        check32("target_instr", InstructionIF, mem_word(32'h0000_1000));

        // PC wrap at the top of the address space
        lat = 0;
        repeat (2) tick();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        check32("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check32("wrap_valid", {31'h0, fetch_valid}, 32'h1);
        check32("wrap_pc4", PC4IF, 32'h0000_0000);
        check32("wrap_instr", InstructionIF, mem_word(32'hFFFF_FFFC));
        check32("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset while in DROP
        lat = 3;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0500;
        discard_next = 1'b1;
        tick();
        redirect = 1'b0;
        reset = 1'b0;
        #1;
        check32("drop_rst_req", {31'h0, imem_req}, 32'h0);
        check32("sb_drained", sb_q.size(), 32'd0);
        tick();
        check32("drop_rst_valid", {31'h0, fetch_valid}, 32'h0);
        check32("drop_rst_instr", InstructionIF, 32'h0);
        check32("drop_rst_pc4", PC4IF, 32'h0);
        discard_next = 1'b0;
        exp_addr = 32'h0000_0040;
        reset = 1'b1;
        #1;
        check32("drop_rst_run_req", {31'h0, imem_req}, 32'h1);
        check32("drop_rst_addr", imem_addr, 32'h0000_0040);
        n = 0;
        while (!fetch_valid && n < 12) begin
            tick();
            n++;
        end
        check32("drop_rst_first_valid", {31'h0, fetch_valid}, 32'h1);
        check32("drop_rst_first_pc4", PC4IF, 32'h0000_0044);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
